uart_rx: RTL and testbench

//  Oversampling UART receiver, directly downstream of the mod-M baud counter.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_flag_buf.sv | 37 +++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   state_t      : receiver FSM states
//   DEF_*        : default frame/oversampling parameters
//   cnt_width()  : width of the oversample-tick counter
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_OS      = 16;

  // The tick counter must reach both OS-1 (data bits) and SB_TICK-1 (stop period).
  function automatic int cnt_width(input int os, input int sb_tick);
    int m;
    m = (os > sb_tick) ? os : sb_tick;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver.
//   rd_uart      : host read strobe (host -> receiver)
//   dout         : held received word
//   rx_full      : dout valid and unread
//   rx_done_tick : one-clock frame-complete pulse
//   frame_err    : stop bit sampled low on the held frame
//   overrun_err  : an unread word was overwritten
// master = receiver side, slave = host side.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rd_uart;
  logic [DBIT-1:0] dout;
  logic            rx_full;
  logic            rx_done_tick;
  logic            frame_err;
  logic            overrun_err;

  modport master (
    input  rd_uart,
    output dout, rx_full, rx_done_tick, frame_err, overrun_err
  );

  modport slave (
    output rd_uart,
    input  dout, rx_full, rx_done_tick, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_flag_buf.sv
// One-word holding buffer with full flag and overrun detection.
//   clk, reset : clock, asynchronous active-high reset
//   clr_flag   : host read; empties the buffer when it is full
//   set_flag   : load din and mark full
//   din / dout : word in / held word (dout keeps its value after a read)
//   flag       : buffer full
//   ovr        : a full, unread word was overwritten (cleared by a read)
module uart_flag_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_flag,
  input  logic         set_flag,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         flag,
  output logic         ovr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
      flag <= 1'b0;
      ovr  <= 1'b0;
    end else if (set_flag) begin
      // A read in the same cycle consumes the old word, so no overrun.
      dout <= din;
      flag <= 1'b1;
      ovr  <= flag & ~clr_flag;
    end else if (clr_flag && flag) begin
      flag <= 1'b0;
      ovr  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (LSB first, one start bit, DBIT data bits, stop period).
//   clk, reset : clock, asynchronous active-high reset
//   rx         : serial line, idle high, asynchronous to clk
//   s_tick     : one-clock oversample strobe (OS per bit)
//   host       : host-side bundle (read strobe, held word, status, error flags)
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int OS      = DEF_OS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  uart_rx_if.master  host
);

  localparam int SW = cnt_width(OS, SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] shift, shift_n;
  logic            done;

  logic            rx_meta, rx_s;
  logic            need_high;
  logic            done_tick_q;
  logic            frame_err_q;
  logic            full;

  // Two-flop synchroniser, preset to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    shift_n = shift;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s && !need_high) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            s_n = '0;
            if (!rx_s) begin
              state_n = DATA;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_n     = '0;
            shift_n = {rx_s, shift[DBIT-1:1]};
            if (n == N_LAST) state_n = STOP;
            else             n_n     = n + 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            state_n = IDLE;
            s_n     = '0;
            done    = 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A frame ending with the line still low (break or bad stop bit) must not
  // re-trigger START until the line has been seen high again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              need_high <= 1'b0;
    else if (done && !rx_s) need_high <= 1'b1;
    else if (rx_s)          need_high <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_tick_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_tick_q <= done;
      if (done)                      frame_err_q <= ~rx_s;
      else if (host.rd_uart && full) frame_err_q <= 1'b0;
    end
  end

  uart_flag_buf #(.W(DBIT)) u_flag_buf (
    .clk      (clk),
    .reset    (reset),
    .clr_flag (host.rd_uart),
    .set_flag (done),
    .din      (shift),
    .dout     (host.dout),
    .flag     (full),
    .ovr      (host.overrun_err)
  );

  assign host.rx_full      = full;
  assign host.rx_done_tick = done_tick_q;
  assign host.frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic clk;
  logic reset;
  logic rx;
  logic s_tick;
  logic rd_main;
  logic rd_co;
  logic armed;
  int   tcnt;
  int   done_cnt;
  int   exp_done;
  int   n_cmp;
  int   n_err;

  uart_rx_if #(.DBIT(8)) ifc ();

  assign ifc.rd_uart = rd_main | rd_co;

  uart_rx #(.DBIT(8), .SB_TICK(16), .OS(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .s_tick (s_tick),
    .host   (ifc.master)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Oversample strobe every 4 clocks (1 bit = 64 clk); also produces a read
  // pulse aligned with the frame-completing edge when armed.
  always @(negedge clk) begin
    tcnt   = (tcnt == 3) ? 0 : tcnt + 1;
    s_tick = (tcnt == 3);
    rd_co  = armed && s_tick && (dut.state == STOP) && (dut.s == 4'd15);
  end

  always @(negedge clk) begin
    if (ifc.rx_done_tick === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (64) @(negedge clk);
    end
    rx = stop;
    repeat (64) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    rd_main = 1'b1;
    @(negedge clk);
    rd_main = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; rd_main = 1'b0; armed = 1'b0;
    tcnt = 0; s_tick = 1'b0; rd_co = 1'b0;
    done_cnt = 0; exp_done = 0; n_cmp = 0; n_err = 0;
    #5 reset = 1'b0;

    // 1: reset pulse mid-idle
    #15 reset = 1'b1;
    #4  reset = 1'b0;
    @(negedge clk);
    chk("rst_dout",   32'(ifc.dout), 32'h00);
    chk("rst_full",   32'(ifc.rx_full), 0);
    chk("rst_done",   32'(ifc.rx_done_tick), 0);
    chk("rst_ferr",   32'(ifc.frame_err), 0);
    chk("rst_ovr",    32'(ifc.overrun_err), 0);
    chk("rst_state",  32'(dut.state), 32'(IDLE));
    repeat (20) @(negedge clk);

    // 2: clean frame 0xA5
    send_frame(8'hA5, 1'b1); exp_done++;
    chk("a5_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("a5_dout",     32'(ifc.dout), 32'hA5);
    chk("a5_full",     32'(ifc.rx_full), 1);
    chk("a5_ferr",     32'(ifc.frame_err), 0);
    chk("a5_ovr",      32'(ifc.overrun_err), 0);
    rd_pulse();
    chk("a5_rd_full",  32'(ifc.rx_full), 0);
    chk("a5_rd_dout",  32'(ifc.dout), 32'hA5);

    // 3: 8-clock low glitch
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("glitch_state",    32'(dut.state), 32'(IDLE));
    chk("glitch_full",     32'(ifc.rx_full), 0);

    // 4: stop bit low
    send_frame(8'h3C, 1'b0); exp_done++;
    chk("3c_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("3c_dout",     32'(ifc.dout), 32'h3C);
    chk("3c_ferr",     32'(ifc.frame_err), 1);
    rd_pulse();
    chk("3c_rd_ferr",  32'(ifc.frame_err), 0);
    chk("3c_rd_full",  32'(ifc.rx_full), 0);

    // 5a: overrun
    send_frame(8'h11, 1'b1); exp_done++;
    send_frame(8'h22, 1'b1); exp_done++;
    chk("ovr_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("ovr_dout",     32'(ifc.dout), 32'h22);
    chk("ovr_flag",     32'(ifc.overrun_err), 1);
    chk("ovr_full",     32'(ifc.rx_full), 1);
    chk("ovr_ferr",     32'(ifc.frame_err), 0);
    rd_pulse();
    chk("ovr_rd_ovr",   32'(ifc.overrun_err), 0);
    chk("ovr_rd_full",  32'(ifc.rx_full), 0);

    // 5b: read coincident with second frame completion
    send_frame(8'h11, 1'b1); exp_done++;
    chk("co_first_dout", 32'(ifc.dout), 32'h11);
    armed = 1'b1;
    send_frame(8'h22, 1'b1); exp_done++;
    armed = 1'b0;
    chk("co_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("co_dout",     32'(ifc.dout), 32'h22);
    chk("co_full",     32'(ifc.rx_full), 1);
    chk("co_ovr",      32'(ifc.overrun_err), 0);
    rd_pulse();
    chk("co_rd_full",  32'(ifc.rx_full), 0);

    // Break: line held low for 12 bit times
    rx = 1'b0;
    repeat (12 * 64) @(negedge clk);
    exp_done++;
    chk("brk_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("brk_dout",     32'(ifc.dout), 32'h00);
    chk("brk_ferr",     32'(ifc.frame_err), 1);
    chk("brk_state",    32'(dut.state), 32'(IDLE));
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("brk_rel_cnt",  32'(done_cnt), 32'(exp_done));
    rd_pulse();

    // 6: reset during bit 4 of 0xFF
    rx = 1'b0;
    repeat (64) @(negedge clk);
    rx = 1'b1;
    repeat (4 * 64 + 32) @(negedge clk);
    chk("rst6_pre_state", 32'(dut.state), 32'(DATA));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (16) @(negedge clk);
    chk("rst6_state",    32'(dut.state), 32'(IDLE));
    chk("rst6_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("rst6_full",     32'(ifc.rx_full), 0);
    chk("rst6_dout",     32'(ifc.dout), 32'h00);
    repeat (64) @(negedge clk);
    send_frame(8'h5A, 1'b1); exp_done++;
    chk("5a_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("5a_dout",     32'(ifc.dout), 32'h5A);
    chk("5a_full",     32'(ifc.rx_full), 1);
    chk("5a_ferr",     32'(ifc.frame_err), 0);
    chk("5a_ovr",      32'(ifc.overrun_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
